// File: rtl/result_display_ctrl.sv
// result_display_ctrl: captures the result of an external 4-bit adder/subtractor
// on a debounced button press, holds it on LEDs and shows it on a 4-digit
// multiplexed 7-segment display.
// Optional feature macro: OVERFLOW_DISPLAY_EN (holds signed overflow, shows 'o' on digit3).
module result_display_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REFRESH_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       mode_i,
    input  logic [3:0] sum_i,
    input  logic       carry_i,
    input  logic       capture_btn_i,
    output logic [4:0] led_o,
    output logic       valid_o,
    output logic       ovf_o,
    output logic [6:0] seg_n_o,
    output logic [3:0] an_n_o
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_LO_O  = 7'h23;  // segments c,d,e,g lit
    localparam logic [6:0]       SEG_ZERO  = 7'h40;
    localparam logic [6:0]       SEG_ONE   = 7'h79;
    localparam logic [6:0]       SEG_A     = 7'h08;
    localparam logic [6:0]       SEG_FIVE  = 7'h12;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             db_level_q;
    logic             db_prev_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [REF_W-1:0] ref_cnt_q;
    logic [1:0]       digit_q;
    logic             mode_q;
    logic             capture_c;
    logic             ovf_new_c;
    logic [3:0]       sum_d;
    logic             carry_d;
    logic             mode_d;
    logic             ovf_d;
    logic [6:0]       seg_d;
    logic [3:0]       an_d;

    // Active-low hex glyphs, bit0 = a .. bit6 = g
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

`ifdef OVERFLOW_DISPLAY_EN
    logic unused_bits;
    assign unused_bits = ^{a_i[2:0], b_i[2:0]};

    // Signed overflow of the external add/subtract, judged from operand and sum sign bits
    assign ovf_new_c = (a_i[3] == (b_i[3] ^ mode_i)) && (sum_i[3] != a_i[3]);

    // Held overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= ovf_d;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{a_i, b_i};
    assign ovf_new_c   = 1'b0;
    assign ovf_o       = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], capture_btn_i};
        end
    end

    // Debouncer: level follows the synchronized input only after a full run of mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            db_prev_q <= db_level_q;
            if (sync_q[1] != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_q <= sync_q[1];
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign capture_c = db_level_q & ~db_prev_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and next held values; a capture pulse loads the inputs
    always_comb begin
        state_d = state_q;
        sum_d   = led_o[3:0];
        carry_d = led_o[4];
        mode_d  = mode_q;
        ovf_d   = ovf_o;
        case (state_q)
            S_EMPTY: if (capture_c) state_d = S_HELD;
            S_HELD:  if (capture_c) state_d = S_HELD;
            default: state_d = S_EMPTY;
        endcase
        if (capture_c) begin
            sum_d   = sum_i;
            carry_d = carry_i;
            mode_d  = mode_i;
            ovf_d   = ovf_new_c;
        end
    end

    // Held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_o   <= 5'b0;
            valid_o <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            led_o   <= {carry_d, sum_d};
            valid_o <= (state_d == S_HELD);
            mode_q  <= mode_d;
        end
    end

    // Refresh counter and active digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            digit_q   <= 2'd0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_q <= '0;
            digit_q   <= digit_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
    end

    // Segment pattern and digit enable for the active digit, built from next held values
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 4'hF;
        case (digit_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = hex_glyph(sum_d);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = carry_d ? SEG_ONE : SEG_ZERO;
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = mode_d ? SEG_FIVE : SEG_A;
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = ovf_d ? SEG_LO_O : SEG_BLANK;
            end
        endcase
        if (state_d != S_HELD) begin
            seg_d = SEG_BLANK;
        end
    end

    // Display output registers, updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_o <= SEG_BLANK;
            an_n_o  <= 4'hF;
        end else begin
            seg_n_o <= seg_d;
            an_n_o  <= an_d;
        end
    end

endmodule

// File: doc/result_display_ctrl.md
RESULT_DISPLAY_CTRL -- requirements
Module: result_display_ctrl

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before the debounced button level changes.
REQ-002 SHALL have parameter: REFRESH_CYCLES, 100000, clk cycles each display digit stays enabled.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, system clock (all logic rising-edge); rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port: a_i  input  4  operand A presented to the 4-bit adder/subtractor.
REQ-005 SHALL have port: b_i  input  4  operand B presented to the 4-bit adder/subtractor, before mode inversion.
REQ-006 SHALL have port: mode_i  input  1  0 = add, 1 = subtract.
REQ-007 SHALL have port: sum_i  input  4  adder/subtractor sum bits.
REQ-008 SHALL have port: carry_i  input  1  adder/subtractor carry-out.
REQ-009 SHALL have port: capture_btn_i  input  1  raw, asynchronous, bouncing push-button, high = pressed.
REQ-010 SHALL have port: led_o  output  5  held {carry, sum}.
REQ-011 SHALL have port: valid_o  output  1  a result is held.
REQ-012 SHALL have port: ovf_o  output  1  held signed-overflow flag.
REQ-013 SHALL have port: seg_n_o  output  7  active-low segments, bit0 = a through bit6 = g.
REQ-014 SHALL have port: an_n_o  output  4  active-low one-hot digit enables, bit0 = rightmost digit.

Function
REQ-015 SHALL pass capture_btn_i through a 2-flop synchronizer, then through a debouncer; the debouncer changes level only after the synchronized value differs from the current level for DEBOUNCE_CYCLES consecutive cycles, and any mismatch break restarts the count.
REQ-016 SHALL generate a one-cycle capture pulse on each debounced rising edge; a debounced falling edge produces no action.
REQ-017 SHALL implement FSM EMPTY -> HELD on a capture pulse, and HELD -> HELD (re-capture) on a capture pulse; there is no other transition except reset.
REQ-018 SHALL sample a_i, b_i, mode_i, sum_i and carry_i in the capture-pulse cycle; led_o, valid_o, ovf_o and the display contents update on the next rising edge.
REQ-019 SHALL compute overflow = (a_i[3] == (b_i[3] XOR mode_i)) AND (sum_i[3] != a_i[3]).
REQ-020 SHALL keep held values unchanged while inputs change, until the next capture pulse.
REQ-021 SHALL advance a refresh counter 0..REFRESH_CYCLES-1 and, on wrap, step the active digit 0 -> 1 -> 2 -> 3 -> 0; exactly one an_n_o bit is low at any time outside reset.
REQ-022 SHALL display, in HELD: digit0 = hex of the held sum (standard 0-F glyphs), digit1 = '0' or '1' for the held carry, digit2 = 'A' (add) or '5' (subtract), digit3 = 'o' (segments c,d,e,g) if overflow else blank.
REQ-023 SHALL drive seg_n_o = 7'h7F (blank) for every digit in EMPTY, while the digit scan still runs.
REQ-024 SHALL register seg_n_o and an_n_o so that they change in the same cycle.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set: FSM = EMPTY, led_o = 0, valid_o = 0, ovf_o = 0, seg_n_o = 7'h7F, an_n_o = 4'hF, all counters, the synchronizer and the debounced level to 0.
REQ-026 SHALL start scanning at digit0 on the first rising edge after rst_n deasserts; if the button is held through reset, a capture requires a full debounce from level 0.

Configuration
REQ-027 SHALL, with OVERFLOW_DISPLAY_EN defined, compute and hold overflow and show it on digit3 per REQ-022.
REQ-028 SHALL, without OVERFLOW_DISPLAY_EN, tie ovf_o to 0, keep digit3 blank, and omit the overflow logic.

Verification (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2, macro defined unless stated)
REQ-029 SHALL cover: a=5, b=3, mode=0, sum=8, carry=0, button high for 10 cycles -> led_o=5'b01000, valid_o=1, ovf_o=1; digit0 seg_n_o=7'h00, digit3 shows 'o'.
REQ-030 SHALL cover: a=3, b=5, mode=1, sum=E, carry=0, clean press -> led_o=5'b01110, ovf_o=0; digit0 seg_n_o=7'h06, digit2 shows '5'.
REQ-031 SHALL cover: button high 2 cycles, low 2 cycles, repeated 5 times -> no capture, valid_o stays 0, all digits blank.
REQ-032 SHALL cover: after a capture, change all inputs with no press -> led_o, ovf_o and the display are unchanged.
REQ-033 SHALL cover: rst_n pulsed low mid-scan while HELD -> outputs take the REQ-025 values immediately, without waiting for a clk edge.
REQ-034 SHALL cover: macro undefined, stimulus as in REQ-029 -> ovf_o=0, digit3 seg_n_o=7'h7F, led_o=5'b01000.
